epoch_alarm: RTL and testbench
==============================

// Module: epoch_alarm
// PURPOSE
//  Downstream consumer of the epoch timer: compares the live 64-bit epoch against a
//  programmed target and raises a level interrupt that holds until acknowledged.
//  Supports one-shot and periodic alarms. Target and period are loaded through the
//  same SPI buffer path that loads the timer. Readback of the target and state goes to the SPI FSM.
// PARAMETERS
//  TIME_WIDTH    64  width of epoch and target
//  PERIOD_WIDTH  32  width of repeat interval, in seconds; 0 = one-shot
// PORTS
//  clk          in   1             system clock (internal oscillator)
//  rst          in   1             asynchronous, active-high reset
//  i_time       in   TIME_WIDTH    live epoch from timer o_time
//  load_enable  in   1             1-cycle strobe: capture i_alarm/i_period
//  i_alarm      in   TIME_WIDTH    target epoch to load
//  i_period     in   PERIOD_WIDTH  repeat interval to load
//  arm          in   1             1-cycle strobe: IDLE -> ARMED
//  disarm       in   1             1-cycle strobe: any state -> IDLE
//  ack          in   1             1-cycle strobe: acknowledge irq
//  irq          out  1             alarm interrupt, level, registered
//  missed       out  1             sticky: a periodic alarm fired again while irq was unacked
//  o_alarm      out  TIME_WIDTH    current target, after any periodic advance
//  o_state      out  2             00 IDLE, 01 ARMED, 10 FIRED
// BEHAVIOUR
//  Reset: state=IDLE, target=0, period=0, irq=0, missed=0, o_alarm=0, o_state=00.
//  Compare: match_q <= (i_time >= target), unsigned. Registered every cycle.
//   - match_q is ignored for the single cycle after any target write (load or advance).
//  Latency: i_time first satisfies >= target at edge N -> match_q at N+1 -> FIRED and irq=1 at N+2.
//  Priority, when events coincide in one cycle: disarm > load_enable > match > ack > arm.
//  IDLE:   arm -> ARMED. Match, ack: ignored.
//  ARMED:  valid match -> FIRED, irq<=1.
//          If period!=0: target<=target+period, wrapping mod 2^TIME_WIDTH.
//  FIRED:  ack -> ARMED if period!=0, else IDLE. irq<=0.
//          Valid match with period!=0: missed<=1 and target advances again; stays FIRED.
//  Wrap:   if target+period carries out, the new target is stored, and period is
//          forced to 0, so the alarm becomes one-shot. This prevents continuous refire.
//  disarm: any state -> IDLE, irq<=0. target, period and missed are retained.
//  load_enable: target<=i_alarm, period<=i_period, state -> IDLE, irq<=0, missed<=0.
//  arm while ARMED/FIRED, or ack while IDLE/ARMED: no effect.
//  Target already in the past at arm: fires via the normal 2-cycle latency path.
//  rst mid-operation: immediate return to reset values; no irq glitch.
//  o_alarm = target register. o_state = state register, 2-bit encoding above.
// STRUCTURE
//  rtc_defs.vh, shared include: `ALARM_IDLE/`ALARM_ARMED/`ALARM_FIRED encodings,
//   and the SPI command codes for alarm load/readback, next to WRCMD/RDCMD.
//  Sub-module epoch_cmp: registered TIME_WIDTH unsigned >= comparator with a
//   valid-suppress input. It is isolated so it can be split into two 32-bit halves
//   if timing at 88.67 MHz fails. Still 1 cycle of total latency to the FSM.
//  Adder: one TIME_WIDTH+1-bit add of target + zero-extended period; the MSB is the carry.
// TESTING
//  1 load alarm=100, period=0; arm; ramp i_time 98,99,100 -> irq=1 exactly 2 clk after
//    i_time=100. ack -> irq=0, state=IDLE.
//  2 load alarm=10, period=5; arm; run to 10 -> irq, o_alarm=15. ack -> ARMED.
//    i_time=15 -> irq again, o_alarm=20.
//  3 periodic period=1, no ack, i_time steps 10->11 -> missed=1, irq stays 1,
//    o_alarm=12. load clears missed.
//  4 alarm=2^64-3, period=5; fire -> o_alarm=2, period forced 0. ack -> IDLE, no refire.
//  5 same cycle: match + disarm -> IDLE, irq=0. Same cycle: load + arm ->
//    load wins, state=IDLE.
//  6 assert rst while FIRED -> irq=0, o_state=00, o_alarm=0 with no clk edge needed.
//    Arm with past target (alarm=5, i_time=50) -> irq after 2 clk.

Source files
------------

// File: rtl/epoch_alarm_pkg.sv
// Shared definitions for the epoch alarm: state encodings and SPI opcodes
// used by the SPI FSM to load and read back the alarm.
package epoch_alarm_pkg;

  localparam int TIME_WIDTH_DEF   = 64;
  localparam int PERIOD_WIDTH_DEF = 32;

  // Encoding is visible on o_state and in SPI readback, so it is fixed.
  typedef enum logic [1:0] {
    ALARM_IDLE  = 2'b00,
    ALARM_ARMED = 2'b01,
    ALARM_FIRED = 2'b10
  } alarm_state_e;

  // SPI opcodes, kept alongside the timer's write/read commands.
  localparam logic [7:0] SPI_WRCMD       = 8'h80;
  localparam logic [7:0] SPI_RDCMD       = 8'h00;
  localparam logic [7:0] SPI_ALARM_WRCMD = 8'h81;
  localparam logic [7:0] SPI_ALARM_RDCMD = 8'h01;

endpackage

// File: rtl/epoch_alarm_cmp.sv
// Registered unsigned "time >= target" comparator with a one-cycle
// suppress. Kept separate so the compare can be split into two pipelined
// halves later without touching the alarm FSM.
module epoch_cmp #(
  parameter int TIME_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TIME_WIDTH-1:0] i_time,
  input  logic [TIME_WIDTH-1:0] i_target,
  input  logic                  i_suppress,
  output logic                  o_match
);

  logic r_ge;
  logic r_valid;

  // Register the compare and whether it was taken against a stable target.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking here would chain flops into combinational paths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ge    <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_ge    <= (i_time >= i_target);
      // A target written on this edge makes the compare just taken stale.
      r_valid <= ~i_suppress;
    end
  end

  assign o_match = r_ge & r_valid;

endmodule

// File: rtl/epoch_alarm.sv
// Epoch alarm: compares the live epoch with a programmed target and raises
// a level interrupt held until acknowledged. One-shot when period is zero,
// otherwise the target advances by period on every fire.
module epoch_alarm
  import epoch_alarm_pkg::*;
#(
  parameter int TIME_WIDTH   = TIME_WIDTH_DEF,
  parameter int PERIOD_WIDTH = PERIOD_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TIME_WIDTH-1:0]   i_time,
  input  logic                    load_enable,
  input  logic [TIME_WIDTH-1:0]   i_alarm,
  input  logic [PERIOD_WIDTH-1:0] i_period,
  input  logic                    arm,
  input  logic                    disarm,
  input  logic                    ack,
  output logic                    irq,
  output logic                    missed,
  output logic [TIME_WIDTH-1:0]   o_alarm,
  output logic [1:0]              o_state
);

  alarm_state_e            r_state,  w_state_nxt;
  logic [TIME_WIDTH-1:0]   r_target, w_target_nxt;
  logic [PERIOD_WIDTH-1:0] r_period, w_period_nxt;
  logic                    r_irq,    w_irq_nxt;
  logic                    r_missed, w_missed_nxt;

  logic [TIME_WIDTH:0]     w_sum;
  logic                    w_match;
  logic                    w_period_nz;
  logic                    w_tgt_wr;

  // Single add; the extra MSB is the carry that detects wrap of the epoch.
  assign w_sum       = {1'b0, r_target}
                     + {{(TIME_WIDTH + 1 - PERIOD_WIDTH){1'b0}}, r_period};
  assign w_period_nz = (r_period != '0);

  epoch_cmp #(
    .TIME_WIDTH (TIME_WIDTH)
  ) u_cmp (
    .clk        (clk),
    .rst        (rst),
    .i_time     (i_time),
    .i_target   (r_target),
    .i_suppress (w_tgt_wr),
    .o_match    (w_match)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ALARM_IDLE;
      r_target <= '0;
      r_period <= '0;
      r_irq    <= 1'b0;
      r_missed <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_target <= w_target_nxt;
      r_period <= w_period_nxt;
      r_irq    <= w_irq_nxt;
      r_missed <= w_missed_nxt;
    end
  end

  // Next-state logic; priority disarm > load > match > ack > arm.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_period_nxt = r_period;
    w_irq_nxt    = r_irq;
    w_missed_nxt = r_missed;
    w_tgt_wr     = 1'b0;

    if (disarm) begin
      w_state_nxt = ALARM_IDLE;
      w_irq_nxt   = 1'b0;
    end else if (load_enable) begin
      w_state_nxt  = ALARM_IDLE;
      w_target_nxt = i_alarm;
      w_period_nxt = i_period;
      w_irq_nxt    = 1'b0;
      w_missed_nxt = 1'b0;
      w_tgt_wr     = 1'b1;
    end else begin
      case (r_state)
        ALARM_IDLE: begin
          if (arm) w_state_nxt = ALARM_ARMED;
        end
        ALARM_ARMED: begin
          if (w_match) begin
            w_state_nxt = ALARM_FIRED;
            w_irq_nxt   = 1'b1;
            if (w_period_nz) begin
              w_target_nxt = w_sum[TIME_WIDTH-1:0];
              w_tgt_wr     = 1'b1;
              // Carry out: the advanced target is behind the epoch forever,
              // so drop to one-shot rather than refire every cycle.
              if (w_sum[TIME_WIDTH]) w_period_nxt = '0;
            end
          end
        end
        ALARM_FIRED: begin
          if (w_match && w_period_nz) begin
            w_missed_nxt = 1'b1;
            w_target_nxt = w_sum[TIME_WIDTH-1:0];
            w_tgt_wr     = 1'b1;
            if (w_sum[TIME_WIDTH]) w_period_nxt = '0;
          end else if (ack) begin
            w_state_nxt = w_period_nz ? ALARM_ARMED : ALARM_IDLE;
            w_irq_nxt   = 1'b0;
          end
        end
        default: begin
          w_state_nxt = ALARM_IDLE;
          w_irq_nxt   = 1'b0;
        end
      endcase
    end
  end

  assign irq     = r_irq;
  assign missed  = r_missed;
  assign o_alarm = r_target;
  assign o_state = r_state;

endmodule

// File: tb/tb_epoch_alarm.sv
// Directed self-checking bench for epoch_alarm.
module tb_epoch_alarm;

  logic        clk;
  logic        rst;
  logic [63:0] i_time;
  logic        load_enable;
  logic [63:0] i_alarm;
  logic [31:0] i_period;
  logic        arm;
  logic        disarm;
  logic        ack;
  logic        irq;
  logic        missed;
  logic [63:0] o_alarm;
  logic [1:0]  o_state;

  int total = 0;
  int bad   = 0;

  epoch_alarm #(
    .TIME_WIDTH   (64),
    .PERIOD_WIDTH (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_time      (i_time),
    .load_enable (load_enable),
    .i_alarm     (i_alarm),
    .i_period    (i_period),
    .arm         (arm),
    .disarm      (disarm),
    .ack         (ack),
    .irq         (irq),
    .missed      (missed),
    .o_alarm     (o_alarm),
    .o_state     (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [63:0] a, input logic [31:0] p);
    i_alarm = a; i_period = p; load_enable = 1'b1;
    step();
    load_enable = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1; step(); arm = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    total++;
    if (irq !== 1'b0 || missed !== 1'b0 || o_state !== 2'b00 || o_alarm !== 64'd0) begin
      bad++;
      $display("FAIL reset: irq=%0b missed=%0b state=%0b alarm=%0h want 0/0/00/0",
               irq, missed, o_state, o_alarm);
    end
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_oneshot();
    i_time = 64'd0;
    do_load(64'd100, 32'd0);
    do_arm();
    i_time = 64'd98; step();
    i_time = 64'd99; step();
    i_time = 64'd100; step();
    total++;
    if (irq !== 1'b0) begin
      bad++; $display("FAIL oneshot_early: irq=%0b want 0", irq);
    end
    step();
    total++;
    if (irq !== 1'b1 || o_state !== 2'b10) begin
      bad++; $display("FAIL oneshot_fire: irq=%0b state=%0b want 1/10", irq, o_state);
    end
    do_ack();
    total++;
    if (irq !== 1'b0 || o_state !== 2'b00) begin
      bad++; $display("FAIL oneshot_ack: irq=%0b state=%0b want 0/00", irq, o_state);
    end
  endtask

  task automatic test_periodic();
    i_time = 64'd0;
    do_load(64'd10, 32'd5);
    do_arm();
    i_time = 64'd10;
    step(); step();
    total++;
    if (irq !== 1'b1 || o_alarm !== 64'd15 || missed !== 1'b0) begin
      bad++; $display("FAIL periodic_fire1: irq=%0b alarm=%0d missed=%0b want 1/15/0",
                      irq, o_alarm, missed);
    end
    step(); step();
    total++;
    if (irq !== 1'b1 || o_alarm !== 64'd15 || missed !== 1'b0) begin
      bad++; $display("FAIL periodic_hold: irq=%0b alarm=%0d missed=%0b want 1/15/0",
                      irq, o_alarm, missed);
    end
    do_ack();
    total++;
    if (irq !== 1'b0 || o_state !== 2'b01) begin
      bad++; $display("FAIL periodic_ack: irq=%0b state=%0b want 0/01", irq, o_state);
    end
    do_ack();
    total++;
    if (o_state !== 2'b01) begin
      bad++; $display("FAIL periodic_ack_armed: state=%0b want 01", o_state);
    end
    i_time = 64'd15;
    step(); step();
    total++;
    if (irq !== 1'b1 || o_alarm !== 64'd20) begin
      bad++; $display("FAIL periodic_fire2: irq=%0b alarm=%0d want 1/20", irq, o_alarm);
    end
    do_arm();
    total++;
    if (o_state !== 2'b10 || irq !== 1'b1) begin
      bad++; $display("FAIL periodic_arm_fired: state=%0b irq=%0b want 10/1", o_state, irq);
    end
  endtask

  task automatic test_missed();
    i_time = 64'd0;
    do_load(64'd10, 32'd1);
    do_arm();
    i_time = 64'd10;
    step(); step();
    total++;
    if (irq !== 1'b1 || o_alarm !== 64'd11 || missed !== 1'b0) begin
      bad++; $display("FAIL missed_fire: irq=%0b alarm=%0d missed=%0b want 1/11/0",
                      irq, o_alarm, missed);
    end
    i_time = 64'd11;
    step(); step();
    total++;
    if (missed !== 1'b1 || irq !== 1'b1 || o_alarm !== 64'd12) begin
      bad++; $display("FAIL missed_set: missed=%0b irq=%0b alarm=%0d want 1/1/12",
                      missed, irq, o_alarm);
    end
    step(); step();
    total++;
    if (o_alarm !== 64'd12 || o_state !== 2'b10) begin
      bad++; $display("FAIL missed_stable: alarm=%0d state=%0b want 12/10", o_alarm, o_state);
    end
    do_load(64'd1000, 32'd0);
    total++;
    if (missed !== 1'b0 || irq !== 1'b0 || o_state !== 2'b00 || o_alarm !== 64'd1000) begin
      bad++; $display("FAIL missed_clear: missed=%0b irq=%0b state=%0b alarm=%0d want 0/0/00/1000",
                      missed, irq, o_state, o_alarm);
    end
  endtask

  task automatic test_wrap();
    i_time = 64'hFFFF_FFFF_FFFF_FFFD;
    do_load(64'hFFFF_FFFF_FFFF_FFFD, 32'd5);
    do_arm();
    step();
    total++;
    if (irq !== 1'b1 || o_alarm !== 64'd2 || o_state !== 2'b10) begin
      bad++; $display("FAIL wrap_fire: irq=%0b alarm=%0h state=%0b want 1/2/10",
                      irq, o_alarm, o_state);
    end
    step(); step();
    total++;
    if (missed !== 1'b0 || o_alarm !== 64'd2) begin
      bad++; $display("FAIL wrap_no_refire: missed=%0b alarm=%0h want 0/2", missed, o_alarm);
    end
    do_ack();
    total++;
    if (o_state !== 2'b00 || irq !== 1'b0) begin
      bad++; $display("FAIL wrap_ack: state=%0b irq=%0b want 00/0", o_state, irq);
    end
    step(); step(); step();
    total++;
    if (o_state !== 2'b00 || irq !== 1'b0) begin
      bad++; $display("FAIL wrap_idle: state=%0b irq=%0b want 00/0", o_state, irq);
    end
  endtask

  task automatic test_priority();
    i_time = 64'd0;
    do_load(64'd10, 32'd0);
    do_arm();
    i_time = 64'd10;
    step();
    disarm = 1'b1; step(); disarm = 1'b0;
    total++;
    if (o_state !== 2'b00 || irq !== 1'b0) begin
      bad++; $display("FAIL prio_disarm: state=%0b irq=%0b want 00/0", o_state, irq);
    end
    step(); step();
    total++;
    if (o_state !== 2'b00 || irq !== 1'b0 || o_alarm !== 64'd10) begin
      bad++; $display("FAIL prio_disarm_hold: state=%0b irq=%0b alarm=%0d want 00/0/10",
                      o_state, irq, o_alarm);
    end
    i_alarm = 64'd500; i_period = 32'd0;
    load_enable = 1'b1; arm = 1'b1;
    step();
    load_enable = 1'b0; arm = 1'b0;
    total++;
    if (o_state !== 2'b00 || o_alarm !== 64'd500) begin
      bad++; $display("FAIL prio_load_arm: state=%0b alarm=%0d want 00/500", o_state, o_alarm);
    end
  endtask

  task automatic test_async_rst_and_past();
    i_time = 64'd0;
    do_load(64'd10, 32'd0);
    do_arm();
    i_time = 64'd10;
    step(); step();
    total++;
    if (irq !== 1'b1) begin
      bad++; $display("FAIL rst_pre_fire: irq=%0b want 1", irq);
    end
    rst = 1'b1;
    #1;
    total++;
    if (irq !== 1'b0 || o_state !== 2'b00 || o_alarm !== 64'd0 || missed !== 1'b0) begin
      bad++; $display("FAIL rst_async: irq=%0b state=%0b alarm=%0d missed=%0b want 0/00/0/0",
                      irq, o_state, o_alarm, missed);
    end
    #2;
    rst = 1'b0;
    step();
    i_time = 64'd50;
    do_load(64'd5, 32'd0);
    do_arm();
    total++;
    if (irq !== 1'b0 || o_state !== 2'b01) begin
      bad++; $display("FAIL past_armed: irq=%0b state=%0b want 0/01", irq, o_state);
    end
    step();
    total++;
    if (irq !== 1'b1 || o_state !== 2'b10) begin
      bad++; $display("FAIL past_fire: irq=%0b state=%0b want 1/10", irq, o_state);
    end
  endtask

  initial begin
    rst = 1'b1; i_time = '0; load_enable = 1'b0; i_alarm = '0; i_period = '0;
    arm = 1'b0; disarm = 1'b0; ack = 1'b0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_missed();
    test_wrap();
    test_priority();
    test_async_rst_and_past();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
